corr_search_ctrl: RTL

Sequencer for the correlation score datapath. Steps the search start coordinate across a rectangular window, one candidate position at a time. At each position it hands the coordinate to the score block, waits for that block's finished flag, and captures the resulting 32-bit score. It keeps the best score and its coordinate, and raises a done pulse when the window has been scanned. It sits between the camera-side control logic, which starts scans, and the correlation score block, which computes one score per start position.

---
 rtl/corr_pkg.sv | 33 +++
 rtl/corr_search_ctrl_if.sv | 33 +++
 rtl/corr_best_tracker.sv | 65 ++++++
 rtl/corr_search_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// corr_pkg: shared types and constants for the correlation search sequencer.
//   state_t  - sequencer state encoding (also exported as a debug output)
//   coord_t  - candidate coordinate (COORD_W bits)
//   score_t  - correlation score (SCORE_W bits)
//   DEF_*    - default search window and timing constants
package corr_pkg;

  localparam int COORD_W = 13;
  localparam int SCORE_W = 32;
  localparam int CNT_W   = 16;
  localparam int POS_W   = 16;

  localparam int unsigned DEF_X_MIN        = 0;
  localparam int unsigned DEF_X_MAX        = 15;
  localparam int unsigned DEF_Y_MIN        = 0;
  localparam int unsigned DEF_Y_MAX        = 15;
  localparam int unsigned DEF_STEP         = 1;
  localparam int unsigned DEF_BUSY_TIMEOUT = 4;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_SETTLE    = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/corr_search_ctrl_if.sv
// corr_search_ctrl_if: link between the search sequencer (master) and the
// correlation score block (slave).
//   oControllerReady - sequencer is scanning; the score block may compute
//   oXstart/oYstart  - candidate start coordinate, stable while ready is high
//                      from ISSUE through SETTLE
//   iFinished        - score block idle/finished flag
//   iScore           - score for the last coordinate
//
// Handshake: the score block drops iFinished after it sees a new coordinate
// with oControllerReady high, raises it again when the score is computed, and
// registers iScore one edge after raising iFinished. A coordinate identical to
// the previous one does not restart the block, so iFinished never drops; the
// sequencer then relies on its busy timeout and the held score.
interface corr_search_ctrl_if;
  import corr_pkg::*;

  logic   oControllerReady;
  coord_t oXstart;
  coord_t oYstart;
  logic   iFinished;
  score_t iScore;

  modport master (
    output oControllerReady, oXstart, oYstart,
    input  iFinished, iScore
  );

  modport slave (
    input  oControllerReady, oXstart, oYstart,
    output iFinished, iScore
  );

endinterface

// File: rtl/corr_best_tracker.sv
// corr_best_tracker: keeps the highest score seen in a scan and where it was.
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   clear_i            - start of a new scan: forget the previous best
//   valid_i            - score_i/x_i/y_i is a new candidate result
//   score_i, x_i, y_i  - candidate score and its coordinate
//   best_score_o, best_x_o, best_y_o - current best result
module corr_best_tracker
  import corr_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   clear_i,
  input  logic   valid_i,
  input  score_t score_i,
  input  coord_t x_i,
  input  coord_t y_i,
  output score_t best_score_o,
  output coord_t best_x_o,
  output coord_t best_y_o
);

  logic   best_valid_q, best_valid_d;
  score_t best_score_q, best_score_d;
  coord_t best_x_q, best_x_d;
  coord_t best_y_q, best_y_d;

  // The first candidate of a scan always loads, even with score 0. After that
  // only a strictly greater score wins, so ties keep the earlier raster position.
  always_comb begin
    best_valid_d = best_valid_q;
    best_score_d = best_score_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    if (clear_i) begin
      best_valid_d = 1'b0;
      best_score_d = '0;
      best_x_d     = '0;
      best_y_d     = '0;
    end else if (valid_i && (!best_valid_q || (score_i > best_score_q))) begin
      best_valid_d = 1'b1;
      best_score_d = score_i;
      best_x_d     = x_i;
      best_y_d     = y_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      best_valid_q <= 1'b0;
      best_score_q <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
    end else begin
      best_valid_q <= best_valid_d;
      best_score_q <= best_score_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
    end
  end

  assign best_score_o = best_score_q;
  assign best_x_o     = best_x_q;
  assign best_y_o     = best_y_q;

endmodule

// File: rtl/corr_search_ctrl.sv
// corr_search_ctrl: steps the correlation start coordinate over a rectangular
// window in raster order (X fastest), collects one score per position from the
// score block and keeps the best one.
//   iCLK, iRST_N         - clock, asynchronous active-low reset
//   iStart               - scan request, honoured in IDLE or DONE
//   iAbort               - return to IDLE, results frozen; beats iStart
//   score_if             - coordinate/ready out, finished/score in
//   oBusy                - scan in progress
//   oDone                - one-cycle pulse on completing a scan
//   oBestScore/X/Y       - best result of the current or last scan
//   oPosCount            - positions evaluated in the current or last scan
//   oState               - sequencer state (debug)
module corr_search_ctrl
  import corr_pkg::*;
#(
  parameter int unsigned X_MIN        = DEF_X_MIN,
  parameter int unsigned X_MAX        = DEF_X_MAX,
  parameter int unsigned Y_MIN        = DEF_Y_MIN,
  parameter int unsigned Y_MAX        = DEF_Y_MAX,
  parameter int unsigned STEP         = DEF_STEP,
  parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic                iStart,
  input  logic                iAbort,
  corr_search_ctrl_if.master  score_if,
  output logic                oBusy,
  output logic                oDone,
  output score_t              oBestScore,
  output coord_t              oBestX,
  output coord_t              oBestY,
  output logic [POS_W-1:0]    oPosCount,
  output state_t              oState
);

  localparam coord_t X_MIN_C = COORD_W'(X_MIN);
  localparam coord_t Y_MIN_C = COORD_W'(Y_MIN);
  // One extra bit so that stepping past a limit near 8191 cannot wrap.
  localparam logic [COORD_W:0] X_MAX_W = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W:0] Y_MAX_W = (COORD_W+1)'(Y_MAX);
  localparam logic [COORD_W:0] STEP_W  = (COORD_W+1)'(STEP);
  localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(BUSY_TIMEOUT);

  state_t            state_q, state_d;
  coord_t            x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              done_q, done_d;
  logic              start_scan, capture;
  logic [COORD_W:0]  x_step, y_step;

  assign x_step  = {1'b0, x_q} + STEP_W;
  assign y_step  = {1'b0, y_q} + STEP_W;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    pos_d      = pos_q;
    done_d     = 1'b0;
    start_scan = 1'b0;
    capture    = 1'b0;
    if (iAbort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (iStart) begin
            state_d    = S_ISSUE;
            x_d        = X_MIN_C;
            y_d        = Y_MIN_C;
            pos_d      = '0;
            start_scan = 1'b1;
          end
        end
        S_ISSUE: begin
          state_d = S_WAIT_BUSY;
          cnt_d   = '0;
        end
        S_WAIT_BUSY: begin
          // Finished never dropping means the score block kept its previous
          // result for this same coordinate; take it after the timeout.
          if (!score_if.iFinished) begin
            state_d = S_WAIT_DONE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == TMO_C) state_d = S_SETTLE;
          end
        end
        S_WAIT_DONE: begin
          if (score_if.iFinished) state_d = S_SETTLE;
        end
        S_SETTLE: begin
          // The score block registers iScore on the edge entering SETTLE,
          // so the value sampled on the exit edge is the fresh one.
          pos_d   = pos_q + 1'b1;
          capture = 1'b1;
          state_d = S_NEXT;
        end
        S_NEXT: begin
          if (x_step <= X_MAX_W) begin
            x_d     = x_step[COORD_W-1:0];
            state_d = S_ISSUE;
          end else if (y_step <= Y_MAX_W) begin
            x_d     = X_MIN_C;
            y_d     = y_step[COORD_W-1:0];
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      done_q  <= done_d;
    end
  end

  corr_best_tracker u_best (
    .clk_i        (iCLK),
    .rst_ni       (iRST_N),
    .clear_i      (start_scan),
    .valid_i      (capture),
    .score_i      (score_if.iScore),
    .x_i          (x_q),
    .y_i          (y_q),
    .best_score_o (oBestScore),
    .best_x_o     (oBestX),
    .best_y_o     (oBestY)
  );

  assign score_if.oControllerReady = (state_q != S_IDLE) && (state_q != S_DONE);
  assign score_if.oXstart          = x_q;
  assign score_if.oYstart          = y_q;
  assign oBusy                     = score_if.oControllerReady;
  assign oDone                     = done_q;
  assign oPosCount                 = pos_q;
  assign oState                    = state_q;

endmodule
